// File: rtl/mp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mp_pkg
// Description : Shared widths, FSM state and owner encodings for mem_arbiter.
// Revision    : 1.0
// ============================================================================
package mp_pkg;

  localparam int c_addr_w = 5;
  localparam int c_data_w = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

  typedef enum logic {
    CPU  = 1'b0,
    HOST = 1'b1
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational 2-way round-robin selector (bit 0 = CPU, bit 1 = HOST).
// Revision    : 1.0
// ============================================================================
module rr_pick
  import mp_pkg::*;
(
  input  logic [1:0] pending,
  input  owner_t     last_owner,
  input  logic [1:0] eligible,
  output logic       grant,
  output owner_t     owner
);

  logic [1:0] w_cand;

  assign w_cand = pending & eligible;
  assign grant  = |w_cand;

  always_comb begin
    owner = CPU;
    if (&w_cand) begin
      // Tie: favour whoever was not granted last
      owner = (last_owner == CPU) ? HOST : CPU;
    end else if (w_cand[1]) begin
      owner = HOST;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin CPU/host arbiter for a single-port memory.
//               Optional macro ARB_HOST_HOLD_EN adds host_hold (blocks CPU grants).
// Revision    : 1.0
// ============================================================================
module mem_arbiter
  import mp_pkg::*;
#(
  parameter int ADDR_W = c_addr_w,
  parameter int DATA_W = c_data_w
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
`ifdef ARB_HOST_HOLD_EN
  input  logic              host_hold,
`endif
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_stall,
  output logic [1:0]        arb_state
);

  arb_state_t        r_state;
  arb_state_t        w_next;
  owner_t            r_owner;
  owner_t            r_last_owner;
  owner_t            w_owner;
  logic [1:0]        r_pend;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_host_rdata;
  logic [DATA_W-1:0] w_rdata;
  logic [1:0]        w_req;
  logic [1:0]        w_ack;
  logic [1:0]        w_elig;
  logic              w_hold;
  logic              w_grant;
  logic              w_take;
  logic              w_issue;
  logic              w_done;

`ifdef ARB_HOST_HOLD_EN
  assign w_hold = host_hold;
`else
  assign w_hold = 1'b0;
`endif

  assign w_req  = {host_req, cpu_req};
  assign w_elig = {1'b1, ~w_hold};

  rr_pick u_pick (
    .pending    (r_pend),
    .last_owner (r_last_owner),
    .eligible   (w_elig),
    .grant      (w_grant),
    .owner      (w_owner)
  );

  always_ff @(posedge Clock) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = IDLE;
    w_take  = 1'b0;
    w_issue = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_next = ISSUE;
          w_take = 1'b1;
        end
      end
      ISSUE: begin
        w_next  = DONE;
        w_issue = 1'b1;
      end
      DONE: begin
        w_done = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_ack[0] = w_done && (r_owner == CPU);
  assign w_ack[1] = w_done && (r_owner == HOST);

  // A req in the ack cycle re-arms the flag; a req while already pending is a no-op
  always_ff @(posedge Clock) begin
    if (!Reset) r_pend <= 2'b00;
    else        r_pend <= w_req | (r_pend & ~w_ack);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_owner      <= CPU;
      r_last_owner <= HOST;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else if (w_take) begin
      r_owner      <= w_owner;
      r_last_owner <= w_owner;
      r_we         <= (w_owner == CPU) ? cpu_we    : host_we;
      r_addr       <= (w_owner == CPU) ? cpu_addr  : host_addr;
      r_wdata      <= (w_owner == CPU) ? cpu_wdata : host_wdata;
    end
  end

  assign w_rdata = r_we ? '0 : mem_rdata;

  // Read data is passed through in the ack cycle and held afterwards
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_cpu_rdata  <= '0;
      r_host_rdata <= '0;
    end else begin
      if (w_ack[0]) r_cpu_rdata  <= w_rdata;
      if (w_ack[1]) r_host_rdata <= w_rdata;
    end
  end

  assign cpu_ack    = w_ack[0];
  assign host_ack   = w_ack[1];
  assign cpu_rdata  = w_ack[0] ? w_rdata : r_cpu_rdata;
  assign host_rdata = w_ack[1] ? w_rdata : r_host_rdata;
  assign mem_en     = w_issue;
  assign mem_we     = w_issue & r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign cpu_stall  = r_pend[0] &&
                      !(((r_state == ISSUE) || (r_state == DONE)) && (r_owner == CPU));
  assign arb_state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed, table-driven bench for mem_arbiter with a 32x8 memory model.
// Revision    : 1.0
// ============================================================================
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_req, cpu_we, host_req, host_we;
  logic [4:0] cpu_addr, host_addr;
  logic [7:0] cpu_wdata, host_wdata;
  logic       cpu_ack, host_ack, cpu_stall;
  logic [7:0] cpu_rdata, host_rdata;
  logic       mem_en, mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic [1:0] arb_state;
`ifdef ARB_HOST_HOLD_EN
  logic       host_hold;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(5), .DATA_W(8)) dut (
    .Clock      (clk),
    .Reset      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
`ifdef ARB_HOST_HOLD_EN
    .host_hold  (host_hold),
`endif
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .cpu_stall  (cpu_stall),
    .arb_state  (arb_state)
  );

  // Memory model: read data appears the cycle after mem_en
  logic [7:0] mem [32];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        mem_rdata     <= 8'hEE;
      end else begin
        mem_rdata     <= mem[mem_addr];
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int cpu_cnt, host_cnt, cpu_at, host_at;
  logic [7:0] cpu_rd, host_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check("ack_exclusive", {31'd0, cpu_ack & host_ack}, 32'd0);
    if (cpu_ack === 1'b1) begin
      cpu_cnt++;
      cpu_at = cyc;
      cpu_rd = cpu_rdata;
    end
    if (host_ack === 1'b1) begin
      host_cnt++;
      host_at = cyc;
      host_rd = host_rdata;
    end
  endtask

  task automatic clear_log();
    cpu_cnt = 0; host_cnt = 0; cpu_at = -1; host_at = -1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    string      name;
    logic       who;    // 0 = CPU, 1 = HOST
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[7];

  // One isolated access, checked cycle by cycle from the req cycle N
  task automatic do_access(input vec_t v);
    if (v.who == 1'b0) begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end else begin
      host_req = 1'b1; host_we = v.we; host_addr = v.addr; host_wdata = v.wdata;
    end
    tick();
    cpu_req = 1'b0; host_req = 1'b0;
    check({v.name, ".n1_state"}, {30'd0, arb_state}, 32'd0);
    check({v.name, ".n1_stall"}, {31'd0, cpu_stall}, {31'd0, ~v.who});
    tick();
    check({v.name, ".n2_mem_en"}, {31'd0, mem_en}, 32'd1);
    check({v.name, ".n2_mem_we"}, {31'd0, mem_we}, {31'd0, v.we});
    check({v.name, ".n2_mem_addr"}, {27'd0, mem_addr}, {27'd0, v.addr});
    check({v.name, ".n2_mem_wdata"}, {24'd0, mem_wdata}, {24'd0, v.wdata});
    check({v.name, ".n2_state"}, {30'd0, arb_state}, 32'd1);
    tick();
    check({v.name, ".n3_acks"}, {30'd0, host_ack, cpu_ack}, v.who ? 32'd2 : 32'd1);
    check({v.name, ".n3_rdata"}, {24'd0, (v.who ? host_rdata : cpu_rdata)}, {24'd0, v.exp});
    check({v.name, ".n3_state"}, {30'd0, arb_state}, 32'd2);
    tick();
    check({v.name, ".n4_idle"}, {28'd0, arb_state, mem_en, mem_we}, 32'd0);
    check({v.name, ".n4_acks"}, {30'd0, host_ack, cpu_ack}, 32'd0);
  endtask

  int n0, m0;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h10 + 8'(i);
    mem[3] = 8'hA5;

    vecs[0] = '{"cpu_rd_03",  1'b0, 1'b0, 5'h03, 8'h00, 8'hA5};
    vecs[1] = '{"host_wr_1f", 1'b1, 1'b1, 5'h1F, 8'h3C, 8'h00};
    vecs[2] = '{"host_rd_07", 1'b1, 1'b0, 5'h07, 8'h00, 8'h17};
    vecs[3] = '{"cpu_rd_1f",  1'b0, 1'b0, 5'h1F, 8'h00, 8'h3C};
    vecs[4] = '{"cpu_wr_07",  1'b0, 1'b1, 5'h07, 8'hC3, 8'h00};
    vecs[5] = '{"host_rd_07b",1'b1, 1'b0, 5'h07, 8'h00, 8'hC3};
    vecs[6] = '{"cpu_rd_00",  1'b0, 1'b0, 5'h00, 8'h00, 8'h10};

    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 5'h0; cpu_wdata = 8'h0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 5'h0; host_wdata = 8'h0;
`ifdef ARB_HOST_HOLD_EN
    host_hold = 1'b0;
`endif
    clear_log();

    // Reset held with both requests asserted
    cpu_req = 1'b1; host_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_acks", {30'd0, host_ack, cpu_ack}, 32'd0);
      check("rst_mem_en", {31'd0, mem_en}, 32'd0);
      check("rst_state", {30'd0, arb_state}, 32'd0);
    end
    rst_n = 1'b1; cpu_req = 1'b0; host_req = 1'b0;
    tick();
    check("post_rst_stall", {31'd0, cpu_stall}, 32'd0);
    check("post_rst_rdata", {24'd0, cpu_rdata}, 32'd0);
    tick();
    check("post_rst_idle", {29'd0, arb_state, mem_en}, 32'd0);

    for (int i = 0; i < 7; i++) do_access(vecs[i]);

    // Contention right after reset: CPU first, host three cycles later
    do_reset(2);
    clear_log();
    cpu_we = 1'b0; cpu_addr = 5'h03; host_we = 1'b0; host_addr = 5'h1F;
    cpu_req = 1'b1; host_req = 1'b1; n0 = cyc;
    tick();
    cpu_req = 1'b0; host_req = 1'b0;
    check("tieA_stall", {31'd0, cpu_stall}, 32'd1);
    repeat (8) tick();
    check("tieA_cpu_at", cpu_at, n0 + 3);
    check("tieA_host_at", host_at, n0 + 6);
    check("tieA_counts", {cpu_cnt[15:0], host_cnt[15:0]}, {16'd1, 16'd1});
    check("tieA_cpu_rd", {24'd0, cpu_rd}, 32'h A5);
    check("tieA_host_rd", {24'd0, host_rd}, 32'h3C);

    // CPU granted last, so the next tie goes to the host; host re-requests in its ack cycle
    do_access(vecs[0]);
    clear_log();
    cpu_req = 1'b1; host_req = 1'b1; n0 = cyc;
    tick();
    cpu_req = 1'b0; host_req = 1'b0;
    tick();
    tick();
    check("tieB_host_first", {30'd0, host_ack, cpu_ack}, 32'd2);
    host_req = 1'b1;
    tick();
    host_req = 1'b0;
    repeat (6) tick();
    check("tieB_cpu_at", cpu_at, n0 + 6);
    check("tieB_host_at", host_at, n0 + 9);
    check("tieB_counts", {cpu_cnt[15:0], host_cnt[15:0]}, {16'd1, 16'd2});

    // Repeated req while already pending is ignored
    clear_log();
    cpu_addr = 5'h00;
    cpu_req = 1'b1; n0 = cyc;
    tick();
    tick();
    cpu_req = 1'b0;
    repeat (7) tick();
    check("dup_cpu_cnt", cpu_cnt, 1);
    check("dup_cpu_at", cpu_at, n0 + 3);
    check("dup_cpu_rd", {24'd0, cpu_rd}, 32'h10);

    // Reset during ISSUE aborts the access
    clear_log();
    cpu_addr = 5'h03;
    cpu_req = 1'b1;
    tick();
    cpu_req = 1'b0;
    tick();
    check("abort_in_issue", {31'd0, mem_en}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_state", {30'd0, arb_state}, 32'd0);
    check("abort_stall", {31'd0, cpu_stall}, 32'd0);
    repeat (5) tick();
    check("abort_no_ack", cpu_cnt, 0);
    check("abort_idle", {29'd0, arb_state, mem_en}, 32'd0);

`ifdef ARB_HOST_HOLD_EN
    // host_hold blocks the CPU while three host writes go through
    do_reset(2);
    clear_log();
    host_hold = 1'b1;
    cpu_addr = 5'h03; cpu_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      host_we = 1'b1; host_addr = 5'(16 + i); host_wdata = 8'(8'hE0 + i);
      host_req = 1'b1;
      tick();
      cpu_req = 1'b0; host_req = 1'b0;
      check("hold_stall_n1", {31'd0, cpu_stall}, 32'd1);
      tick();
      check("hold_stall_n2", {31'd0, cpu_stall}, 32'd1);
      tick();
      check("hold_host_ack", {30'd0, host_ack, cpu_ack}, 32'd2);
      check("hold_stall_n3", {31'd0, cpu_stall}, 32'd1);
      tick();
      check("hold_stall_n4", {31'd0, cpu_stall}, 32'd1);
    end
    check("hold_counts", {cpu_cnt[15:0], host_cnt[15:0]}, {16'd0, 16'd3});
    host_hold = 1'b0; m0 = cyc;
    repeat (4) tick();
    check("hold_release_at", cpu_at, m0 + 2);
    check("hold_release_cnt", cpu_cnt, 1);
    check("hold_release_rd", {24'd0, cpu_rd}, 32'hA5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard bound so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
